// File: rtl/niosmp_debug_cross_trigger.sv
// Multiprocessor debug cross-trigger: one core entering debug halts every other
// participating core, and the source core's resume releases the rest.
module niosmp_debug_cross_trigger #(
  parameter int NUM_CORES   = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int SRC_W       = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] cfg_mask,
  input  logic [NUM_CORES-1:0] core_debugack,
  input  logic                 clear_err,
  output logic [NUM_CORES-1:0] debugreq,
  output logic [NUM_CORES-1:0] core_resume,
  output logic [SRC_W-1:0]     halt_source,
  output logic                 halt_source_valid,
  output logic                 all_halted,
  output logic                 timeout_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HALTING = 2'd1;
  localparam logic [1:0] S_HALTED  = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  // The counter starts at 0 on entry, so its last allowed value is one short of the limit.
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [1:0]           state;
  logic [NUM_CORES-1:0] ack_q;
  logic [NUM_CORES-1:0] act_mask;
  logic [7:0]           cnt;

  logic [NUM_CORES-1:0] rise;
  logic [NUM_CORES-1:0] rise_oh;
  logic [SRC_W-1:0]     rise_idx;
  logic [NUM_CORES-1:0] src_oh;
  logic [NUM_CORES-1:0] others;
  logic                 halt_done;
  logic                 cnt_last;

  // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
  always_comb begin
    rise     = core_debugack & ~ack_q & cfg_mask;
    rise_oh  = rise & (~rise + NUM_CORES'(1));
    rise_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = SRC_W'(i);
    end
  end

  assign src_oh    = NUM_CORES'(1) << halt_source;
  assign others    = act_mask & ~src_oh;
  assign halt_done = &(core_debugack | ~act_mask | src_oh);
  assign cnt_last  = (cnt == CNT_LAST);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      ack_q             <= '0;
      act_mask          <= '0;
      cnt               <= '0;
      debugreq          <= '0;
      core_resume       <= '0;
      halt_source       <= '0;
      halt_source_valid <= 1'b0;
      all_halted        <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      ack_q       <= core_debugack;
      core_resume <= '0;
      // A timeout set later in this block overrides a same-cycle clear.
      if (clear_err) timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (|rise) begin
            state             <= S_HALTING;
            halt_source       <= rise_idx;
            act_mask          <= cfg_mask;
            cnt               <= '0;
            halt_source_valid <= 1'b1;
            debugreq          <= cfg_mask & ~rise_oh & ~core_debugack;
          end
        end

        S_HALTING: begin
          cnt <= cnt + 8'd1;
          if (halt_done) begin
            state      <= S_HALTED;
            all_halted <= 1'b1;
            debugreq   <= '0;
          end else if (cnt_last) begin
            state       <= S_HALTED;
            timeout_err <= 1'b1;
            debugreq    <= '0;
          end else begin
            debugreq <= others & ~core_debugack;
          end
        end

        S_HALTED: begin
          debugreq <= '0;
          if (!core_debugack[halt_source]) begin
            core_resume <= others & core_debugack;
            all_halted  <= 1'b0;
            cnt         <= '0;
            state       <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          cnt <= cnt + 8'd1;
          if (~|(core_debugack & act_mask)) begin
            state             <= S_IDLE;
            halt_source_valid <= 1'b0;
          end else if (cnt_last) begin
            state             <= S_IDLE;
            halt_source_valid <= 1'b0;
            timeout_err       <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_niosmp_debug_cross_trigger.sv
// Scoreboard bench: a stimulus process predicts outputs with a behavioural model,
// a monitor process compares them against the DUT once per cycle.
module tb_niosmp_debug_cross_trigger;

  localparam int NC = 4;
  localparam int T  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cfg_mask = '0;
  logic [3:0] core_debugack = '0;
  logic       clear_err = 1'b0;
  logic [3:0] debugreq;
  logic [3:0] core_resume;
  logic [1:0] halt_source;
  logic       halt_source_valid;
  logic       all_halted;
  logic       timeout_err;

  always #5 clk = ~clk;

  niosmp_debug_cross_trigger #(
    .NUM_CORES  (NC),
    .ACK_TIMEOUT(T)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_mask         (cfg_mask),
    .core_debugack    (core_debugack),
    .clear_err        (clear_err),
    .debugreq         (debugreq),
    .core_resume      (core_resume),
    .halt_source      (halt_source),
    .halt_source_valid(halt_source_valid),
    .all_halted       (all_halted),
    .timeout_err      (timeout_err)
  );

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] res;
    logic [1:0] src;
    logic       hsv;
    logic       allh;
    logic       terr;
  } outs_t;

  typedef struct {
    int unsigned cyc;
    string       tag;
    outs_t       exp;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned edges = 0;
  int          checks = 0;
  int          errors = 0;
  string       cur_tag = "reset";

  always @(posedge clk) edges <= edges + 1;

  // Behavioural model: a halt episode described as wait-trigger / stopping / stopped / releasing.
  typedef enum {WAIT_TRIGGER, STOPPING, STOPPED, RELEASING} phase_t;
  phase_t     ph = WAIT_TRIGGER;
  logic [3:0] m_prev = '0;
  logic [3:0] m_part = '0;
  int         m_src = 0;
  int         m_elapsed = 0;
  outs_t      m = '0;

  task automatic model_step(input logic [3:0] msk, input logic [3:0] ack,
                            input logic clr, input logic rst);
    logic [3:0] rise, others;
    bit         set_err;
    if (rst) begin
      ph = WAIT_TRIGGER; m_prev = '0; m_part = '0; m_src = 0; m_elapsed = 0; m = '0;
      return;
    end
    set_err = 0;
    m.res   = '0;
    others  = m_part & ~(4'b0001 << m_src);
    case (ph)
      WAIT_TRIGGER: begin
        rise = ack & ~m_prev & msk;
        if (rise != 0) begin
          for (int i = NC - 1; i >= 0; i--) if (rise[i]) m_src = i;
          m_part    = msk;
          m_elapsed = 0;
          ph        = STOPPING;
          m.hsv     = 1'b1;
          m.src     = 2'(m_src);
          m.req     = msk & ~(4'b0001 << m_src) & ~ack;
        end
      end
      STOPPING: begin
        if ((others & ~ack) == 0) begin
          ph = STOPPED; m.allh = 1'b1; m.req = '0;
        end else if (m_elapsed + 1 == T) begin
          ph = STOPPED; set_err = 1; m.req = '0;
        end else begin
          m.req = others & ~ack;
        end
        m_elapsed++;
      end
      STOPPED: begin
        m.req = '0;
        if (!ack[m_src]) begin
          m.res = others & ack; m.allh = 1'b0; m_elapsed = 0; ph = RELEASING;
        end
      end
      RELEASING: begin
        if ((ack & m_part) == 0) begin
          ph = WAIT_TRIGGER; m.hsv = 1'b0;
        end else if (m_elapsed + 1 == T) begin
          ph = WAIT_TRIGGER; m.hsv = 1'b0; set_err = 1;
        end
        m_elapsed++;
      end
      default: ph = WAIT_TRIGGER;
    endcase
    if (set_err) m.terr = 1'b1;
    else if (clr) m.terr = 1'b0;
    m_prev = ack;
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cycle(input logic [3:0] msk, input logic [3:0] ack,
                       input logic clr, input logic rst);
    sb_t it;
    @(posedge clk);
    #1;
    cfg_mask = msk; core_debugack = ack; clear_err = clr; reset = rst;
    model_step(msk, ack, clr, rst);
    it.cyc = edges + 1;
    it.tag = cur_tag;
    it.exp = m;
    sb_q.push_back(it);
  endtask

  task automatic hold(input logic [3:0] msk, input logic [3:0] ack,
                      input logic clr, input logic rst, input int n);
    for (int i = 0; i < n; i++) cycle(msk, ack, clr, rst);
  endtask

  task automatic check(input string name, input int unsigned cyc,
                       input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got req=%b res=%b src=%0d hsv=%b all=%b err=%b expected req=%b res=%b src=%0d hsv=%b all=%b err=%b",
               name, cyc, act.req, act.res, act.src, act.hsv, act.allh, act.terr,
               exp.req, exp.res, exp.src, exp.hsv, exp.allh, exp.terr);
    end
  endtask

  initial begin : monitor
    sb_t   it;
    outs_t act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= edges) begin
        it  = sb_q.pop_front();
        act = {debugreq, core_resume, halt_source, halt_source_valid, all_halted, timeout_err};
        check(it.tag, it.cyc, act, it.exp);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] a, msk;
    logic       clr, rst;

    cur_tag = "reset";
    hold(4'hF, 4'h0, 1'b0, 1'b1, 2);
    hold(4'hF, 4'h0, 1'b0, 1'b0, 2);

    cur_tag = "core2_halt";
    hold(4'hF, 4'b0100, 1'b0, 1'b0, 3);
    hold(4'hF, 4'b1111, 1'b0, 1'b0, 3);
    cur_tag = "core2_resume";
    hold(4'hF, 4'b1011, 1'b0, 1'b0, 1);
    hold(4'hF, 4'b0000, 1'b0, 1'b0, 2);

    cur_tag = "dual_rise";
    hold(4'hF, 4'b1010, 1'b0, 1'b0, 2);
    hold(4'hF, 4'b1111, 1'b0, 1'b0, 2);
    hold(4'hF, 4'b1101, 1'b0, 1'b0, 1);
    hold(4'hF, 4'b0000, 1'b0, 1'b0, 2);

    cur_tag = "halt_timeout";
    hold(4'hF, 4'b0010, 1'b0, 1'b0, 1);
    hold(4'hF, 4'b1110, 1'b0, 1'b0, 10);
    cur_tag = "clear_err";
    hold(4'hF, 4'b1110, 1'b1, 1'b0, 1);
    hold(4'hF, 4'b0000, 1'b0, 1'b0, 3);

    cur_tag = "masked_core";
    hold(4'b0011, 4'b1000, 1'b0, 1'b0, 2);
    hold(4'b0011, 4'b1001, 1'b0, 1'b0, 2);
    hold(4'b0011, 4'b1011, 1'b0, 1'b0, 2);
    hold(4'b0011, 4'b1010, 1'b0, 1'b0, 1);
    hold(4'b0011, 4'b0000, 1'b0, 1'b0, 2);

    cur_tag = "reset_mid_halt";
    hold(4'hF, 4'b0001, 1'b0, 1'b0, 2);
    hold(4'hF, 4'b0001, 1'b0, 1'b1, 1);
    hold(4'hF, 4'b0000, 1'b0, 1'b0, 1);
    hold(4'hF, 4'b0001, 1'b0, 1'b0, 2);
    hold(4'hF, 4'b1111, 1'b0, 1'b0, 2);
    hold(4'hF, 4'b0000, 1'b0, 1'b0, 3);

    // Randomised cores: they tend to ack when requested and to leave debug after a resume.
    cur_tag = "random";
    msk = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      a = core_debugack;
      for (int i = 0; i < NC; i++) begin
        if (!a[i]) begin
          if ((m.req[i] && $urandom_range(2) == 0) || $urandom_range(29) == 0) a[i] = 1'b1;
        end else begin
          if ((m.res[i] && $urandom_range(1) == 0) || $urandom_range(14) == 0) a[i] = 1'b0;
        end
      end
      if ($urandom_range(49) == 0) msk = 4'($urandom_range(15));
      clr = ($urandom_range(19) == 0);
      rst = ($urandom_range(499) == 0);
      cycle(msk, a, clr, rst);
    end

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/niosmp_debug_cross_trigger.md
# niosmp_debug_cross_trigger

Multiprocessor debug cross-trigger controller for the niosmp system. It watches each Nios II core's debug-acknowledge, and when one core enters debug mode it drives debug requests to halt every other participating core. On resume it sequences the release of the remaining cores. It sits between the per-core JTAG debug modules and the cores' debugreq/resume inputs, so the host debugger sees an all-stop/all-go system.

## Interface
- NUM_CORES, 4: number of cores, legal 2..8.
- ACK_TIMEOUT, 64: cycles allowed for halt or drain completion, legal 2..255.
- SRC_W, clog2(NUM_CORES): width of halt_source (derived).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cfg_mask  in  NUM_CORES  cores participating in cross-trigger; sampled only in IDLE.
- core_debugack  in  NUM_CORES  per-core "in debug mode" level.
- clear_err  in  1  clears timeout_err.
- debugreq  out  NUM_CORES  per-core halt request level.
- core_resume  out  NUM_CORES  one-cycle resume pulse per core.
- halt_source  out  SRC_W  index of the core that caused the current halt.
- halt_source_valid  out  1  halt_source meaningful (HALTING..DRAIN).
- all_halted  out  1  every active core acknowledged the halt.
- timeout_err  out  1  sticky halt/drain timeout flag.

## Operation
- Registers: ack_q (previous core_debugack), act_mask, src, FSM state, timeout counter (8 bits).
- Reset values: debugreq=0, core_resume=0, halt_source=0, halt_source_valid=0, all_halted=0, timeout_err=0, state=IDLE, ack_q=0, act_mask=0, counter=0.
- Trigger: rise = core_debugack & ~ack_q & cfg_mask. This is evaluated only in IDLE. Edges seen in other states are ignored.
- IDLE: if rise≠0, then src = lowest set index of rise and act_mask = cfg_mask, and the FSM goes to HALTING. A cfg_mask of 0 never triggers.
- HALTING:
  - debugreq[j] = act_mask[j] & (j≠src) & ~core_debugack[j]. This is registered, so each bit drops the cycle after its ack is seen.
  - When (core_debugack | ~act_mask | src one-hot) is all ones: go to HALTED and set all_halted=1.
  - If the counter reaches ACK_TIMEOUT first: set timeout_err, go to HALTED with all_halted=0, and clear all debugreq.
- HALTED:
  - debugreq=0.
  - When core_debugack[src]==0 (the host resumed the source core): pulse core_resume[j] for one cycle for every j≠src with act_mask[j] & core_debugack[j]. Then clear all_halted and go to DRAIN.
- DRAIN:
  - When (core_debugack & act_mask)==0: go to IDLE and drop halt_source_valid.
  - On counter==ACK_TIMEOUT: set timeout_err and go to IDLE.
- Counter: clears on entry to HALTING and to DRAIN, and increments every cycle in those states. Timeout means ACK_TIMEOUT cycles elapsed without completion.
- halt_source holds its value after returning to IDLE, until the next trigger.
- timeout_err: clear_err clears it. If a set and a clear happen in the same cycle, set wins.
- A cfg_mask change outside IDLE has no effect until the next trigger.
- A source core that leaves debug during HALTING does not abort the halt. HALTED then sees core_debugack[src]==0 and issues resume on its first cycle.
- Reset asserted in any state returns every register to its reset value at that edge. No resume pulse is issued.

## Timing
- Edge detect: an ack rising in cycle t gives state=HALTING and debugreq asserted in cycle t+1.
- The final ack seen in cycle t gives HALTED and all_halted=1 in cycle t+1.
- core_debugack[src] low in cycle t gives core_resume high in cycle t+1 only, with state=DRAIN.
- HALTING timeout: entry at cycle e gives timeout_err=1 and HALTED at cycle e+ACK_TIMEOUT.
- Every output is registered. There are no combinational input-to-output paths.

## Test plan
- NUM_CORES=4, cfg_mask=4'b1111, core 2 acks. Required: halt_source=2 and debugreq=4'b1011 next cycle. Cores 0, 1, 3 ack 3 cycles later. Required: debugreq=0 and all_halted=1 one cycle after the last ack.
- Cores 1 and 3 rise in the same cycle. Required: halt_source=1 and debugreq=4'b0101.
- Halted system, core_debugack[src] drops. Required: exactly one cycle of core_resume=others-still-acked. When all acks are low, IDLE follows and halt_source_valid=0.
- Core 0 never acks, ACK_TIMEOUT=8. Required: timeout_err=1 and HALTED with all_halted=0 exactly 8 cycles after HALTING entry. clear_err then gives timeout_err=0.
- cfg_mask=4'b0011 and core 3 acks. Required: no trigger. Core 0 acks. Required: debugreq=4'b0010 only, with no request to cores 2/3.
- Reset pulsed mid-HALTING. Required: all outputs 0 and state IDLE next cycle. A fresh ack rise then triggers normally.
